exbus_arbiter: RTL and testbench
================================

# exbus_arbiter

Arbitrates the single external memory bus between the instruction-fetch side (the fetch unit's external-instruction port: `exIns_ren`/`exIns_addr`/`exIns_valid`/`exIns_in`) and the data side (load/store unit accesses beyond local memory). It grants one requester at a time, round-robin when both contend, and drives one bus transaction per grant. It returns read data with a one-cycle `*_valid` pulse and, optionally, aborts transactions the bus never acknowledges.

## Interface
- `TIMEOUT`, 16: max bus cycles waited for `bus_ack` before abort (only with `EXBUS_TIMEOUT_EN`); legal range 2..255.
- `NOP_INS`, 32'h00000013: instruction returned on an aborted instruction fetch.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `nrst`  in  1  reset; one clock, reset asynchronous and active-low.
- `ins_req`  in  1  instruction fetch request (level); held until `ins_valid`.
- `ins_addr`  in  32  fetch address.
- `ins_valid`  out  1  one-cycle pulse: `ins_rdata` valid.
- `ins_rdata`  out  32  fetched instruction.
- `dat_req`  in  1  data request (level); held until `dat_valid`.
- `dat_we`  in  1  1 = write, 0 = read.
- `dat_addr`  in  32  data address.
- `dat_wdata`  in  32  write data.
- `dat_valid`  out  1  one-cycle completion pulse.
- `dat_rdata`  out  32  read data; 0 for writes.
- `bus_req`  out  1  bus transaction active.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  32  bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_ack`  in  1  bus completes current transaction this cycle.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `err_clr`  in  1  clears `timeout_err`.
- `timeout_err`  out  1  sticky: a transaction was aborted.

## Operation
- States: `IDLE`, `INS`, `DAT`. In `INS`/`DAT`, `bus_req` = 1; in `IDLE`, `bus_req` = 0.
- Effective request = `*_req & ~*_valid`. This masks the cycle in which the requester sees its own completion pulse.
- `IDLE`:
  - If only one effective request, grant it.
  - If both, grant the side not granted last. The `last` pointer resets to DAT, so INS wins the first contention.
  - On grant: register `bus_addr`, `bus_we` (0 for INS), `bus_wdata` (0 for INS), and update `last`.
- `INS`/`DAT`:
  - Bus outputs are stable for the whole transaction; requester input changes are ignored.
  - On `bus_ack`: capture `bus_rdata` into that side's rdata (`dat_rdata` = 0 if write), pulse that side's `valid` next cycle, and return to `IDLE`.
- `bus_ack` in `IDLE` is ignored.
- `ins_rdata`/`dat_rdata` hold their value until the next completion on the same side.
- Reset values: state `IDLE`, all outputs 0, `last` = DAT, wait counter 0. Reset asserted mid-transaction drops `bus_req` immediately (asynchronous), with no `valid` pulse.

## Timing
- Request sampled high in `IDLE` at edge n → `bus_req` = 1 from n+1.
- `bus_ack` sampled at edge m → `bus_req` = 0 and `*_valid` = 1 from m+1 for exactly one cycle.
- Minimum request-to-valid latency is 2 cycles. Bus idles at least 1 cycle between transactions.
- Back-to-back contention alternates INS, DAT, INS, … with one idle cycle between grants.
- Wait counter:
  - Cleared on grant; increments each `INS`/`DAT` cycle without ack; 8 bits.
  - When it equals `TIMEOUT-1` with no ack, the transaction aborts at that edge: `bus_req` has been high exactly `TIMEOUT` cycles.
  - Ack on the abort cycle wins; it is a normal completion.
- Abort: return to `IDLE`, pulse `*_valid`, with `ins_rdata` = `NOP_INS` or `dat_rdata` = 0, and set `timeout_err`.
- `timeout_err`: `err_clr` clears it next edge. A simultaneous set wins over clear.

## Configuration
- `EXBUS_TIMEOUT_EN` defined: wait counter, abort path and `timeout_err` are compiled in, as above.
- `EXBUS_TIMEOUT_EN` undefined: no counter; a transaction waits for `bus_ack` indefinitely; `timeout_err` is tied to 0; `err_clr` and `TIMEOUT` are unused.

## Test plan
- Single INS:
  - Stimulus: `ins_req` = 1, `ins_addr` = 32'h804; bus acks 3 cycles after `bus_req` rises with `bus_rdata` = 32'h00a00093.
  - Response: `bus_addr` = 32'h804, `bus_we` = 0; one-cycle `ins_valid` with `ins_rdata` = 32'h00a00093; `bus_req` falls the cycle after ack.
- Contention:
  - Stimulus: `ins_req` and `dat_req` both held from reset release; bus acks immediately every transaction.
  - Response: grants INS, DAT, INS, DAT; each `valid` pulse is single-cycle; idle gap of 1 cycle between grants.
- Data write:
  - Stimulus: `dat_we` = 1, `dat_addr` = 32'h900, `dat_wdata` = 32'hdeadbeef; ack with `bus_rdata` = 32'h1234.
  - Response: `bus_we` = 1, `bus_wdata` = 32'hdeadbeef; `dat_valid` pulse with `dat_rdata` = 0.
- Timeout (with macro, `TIMEOUT` = 4):
  - Stimulus: INS request, no ack.
  - Response: `bus_req` high exactly 4 cycles; then `ins_valid` with `ins_rdata` = 32'h00000013; `timeout_err` = 1 until `err_clr`.
- Ack on the abort cycle (with macro): normal completion, `timeout_err` stays 0.
- Reset mid-operation: `nrst` low during `DAT` wait → `bus_req` = 0 without waiting for a clock edge; no `dat_valid`; after release, first contention grants INS.

Source files
------------

// File: rtl/exbus_arbiter.sv
// exbus_arbiter: round-robin arbiter between instruction fetch and data side for one external bus.
// Define EXBUS_TIMEOUT_EN to compile in the ack wait counter, abort path and timeout_err.
module exbus_arbiter #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP_INS = 32'h00000013
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ins_req,
  input  logic [31:0] ins_addr,
  output logic        ins_valid,
  output logic [31:0] ins_rdata,
  input  logic        dat_req,
  input  logic        dat_we,
  input  logic [31:0] dat_addr,
  input  logic [31:0] dat_wdata,
  output logic        dat_valid,
  output logic [31:0] dat_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        err_clr,
  output logic        timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, INS = 2'd1, DAT = 2'd2;
  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        ins_valid_q, ins_valid_d, dat_valid_q, dat_valid_d;
  logic [31:0] ins_rdata_q, ins_rdata_d, dat_rdata_q, dat_rdata_d;
  logic        ins_eff, dat_eff, pick_ins, pick_dat, busy, grant, done, ins_done, dat_done, abort;
`ifdef EXBUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  assign abort = busy & ~bus_ack & (cnt_q == 8'(TIMEOUT - 1));
  assign cnt_d = grant ? 8'd0 : (busy & ~bus_ack) ? cnt_q + 8'd1 : cnt_q;
  assign err_d = abort ? 1'b1 : err_clr ? 1'b0 : err_q;
  assign timeout_err = err_q;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign abort = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // last_q = 1 means DAT was granted last, so INS wins the next tie
  always_comb begin
    ins_eff     = ins_req & ~ins_valid_q;
    dat_eff     = dat_req & ~dat_valid_q;
    pick_ins    = ins_eff & (~dat_eff | last_q);
    pick_dat    = dat_eff & (~ins_eff | ~last_q);
    busy        = state_q != IDLE;
    grant       = ~busy & (pick_ins | pick_dat);
    done        = busy & (bus_ack | abort);
    ins_done    = done & (state_q == INS);
    dat_done    = done & (state_q == DAT);
    state_d     = !busy ? (pick_ins ? INS : pick_dat ? DAT : IDLE) : done ? IDLE : state_q;
    last_d      = grant ? pick_dat : last_q;
    addr_d      = grant ? (pick_ins ? ins_addr : dat_addr) : addr_q;
    we_d        = grant ? pick_dat & dat_we : we_q;
    wdata_d     = grant ? (pick_ins ? 32'd0 : dat_wdata) : wdata_q;
    ins_valid_d = ins_done;
    dat_valid_d = dat_done;
    ins_rdata_d = ins_done ? (bus_ack ? bus_rdata : NOP_INS) : ins_rdata_q;
    dat_rdata_d = dat_done ? ((bus_ack & ~we_q) ? bus_rdata : 32'd0) : dat_rdata_q;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      ins_valid_q <= 1'b0;
      dat_valid_q <= 1'b0;
      ins_rdata_q <= 32'd0;
      dat_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ins_valid_q <= ins_valid_d;
      dat_valid_q <= dat_valid_d;
      ins_rdata_q <= ins_rdata_d;
      dat_rdata_q <= dat_rdata_d;
    end
  assign bus_req   = state_q != IDLE;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign ins_valid = ins_valid_q;
  assign ins_rdata = ins_rdata_q;
  assign dat_valid = dat_valid_q;
  assign dat_rdata = dat_rdata_q;
endmodule

// File: tb/tb_exbus_arbiter.sv
// tb_exbus_arbiter: vector table plus hand sequences for timeout and reset corners of exbus_arbiter.
module tb_exbus_arbiter;
  localparam logic H = 1'b1, L = 1'b0;
  logic clk, nrst, ins_req, dat_req, dat_we, bus_ack, err_clr;
  logic [31:0] ins_addr, dat_addr, dat_wdata, bus_rdata;
  logic ins_valid, dat_valid, bus_req, bus_we, timeout_err;
  logic [31:0] ins_rdata, dat_rdata, bus_addr, bus_wdata;
  int checks = 0, errors = 0, step = 0;
  logic [31:0] ird_h, drd_h;

  exbus_arbiter #(.TIMEOUT(4), .NOP_INS(32'h00000013)) dut (
    .clk(clk), .nrst(nrst),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_valid(ins_valid), .ins_rdata(ins_rdata),
    .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata),
    .dat_valid(dat_valid), .dat_rdata(dat_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic ir; logic [31:0] ia; logic dr, dw; logic [31:0] da, dd; logic ack; logic [31:0] rd; logic clr;
    logic breq, bwe; logic [31:0] ba, bwd; logic iv; logic [31:0] ird; logic dv; logic [31:0] drd; logic terr;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd, input logic ack,
                              input logic [31:0] rd, input logic clr, input logic breq, input logic bwe,
                              input logic [31:0] ba, input logic [31:0] bwd, input logic iv,
                              input logic [31:0] ird, input logic dv, input logic [31:0] drd,
                              input logic terr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.ack = ack; v.rd = rd; v.clr = clr;
    v.breq = breq; v.bwe = bwe; v.ba = ba; v.bwd = bwd; v.iv = iv; v.ird = ird; v.dv = dv; v.drd = drd;
    v.terr = terr;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step, n, got, exp);
    end
  endtask

  task automatic run(input vec_t v);
    ins_req = v.ir; ins_addr = v.ia; dat_req = v.dr; dat_we = v.dw; dat_addr = v.da; dat_wdata = v.dd;
    bus_ack = v.ack; bus_rdata = v.rd; err_clr = v.clr;
    @(posedge clk);
    #1;
    chk("bus_req", 32'(bus_req), 32'(v.breq));
    if (v.breq) begin
      chk("bus_we", 32'(bus_we), 32'(v.bwe));
      chk("bus_addr", bus_addr, v.ba);
      chk("bus_wdata", bus_wdata, v.bwd);
    end
    chk("ins_valid", 32'(ins_valid), 32'(v.iv));
    chk("ins_rdata", ins_rdata, v.ird);
    chk("dat_valid", 32'(dat_valid), 32'(v.dv));
    chk("dat_rdata", dat_rdata, v.drd);
    chk("timeout_err", 32'(timeout_err), 32'(v.terr));
    step++;
  endtask

  initial begin
    // single fetch, data write, data read, idle ack, contention and round-robin tie-break
    tbl[0]  = mk(H,'h804,L,L,0,0,L,0,L,                 H,L,'h804,0,L,0,L,0,L);
    tbl[1]  = mk(H,'h804,L,L,0,0,L,0,L,                 H,L,'h804,0,L,0,L,0,L);
    tbl[2]  = mk(H,'h804,L,L,0,0,L,0,L,                 H,L,'h804,0,L,0,L,0,L);
    tbl[3]  = mk(H,'h804,L,L,0,0,H,'h00a00093,L,        L,L,0,0,H,'h00a00093,L,0,L);
    tbl[4]  = mk(H,'h804,L,L,0,0,L,0,L,                 L,L,0,0,L,'h00a00093,L,0,L);
    tbl[5]  = mk(L,0,L,L,0,0,L,0,L,                     L,L,0,0,L,'h00a00093,L,0,L);
    tbl[6]  = mk(L,0,H,H,'h900,'hdeadbeef,L,0,L,        H,H,'h900,'hdeadbeef,L,'h00a00093,L,0,L);
    tbl[7]  = mk(L,0,H,H,'h900,'hdeadbeef,H,'h1234,L,   L,L,0,0,L,'h00a00093,H,0,L);
    tbl[8]  = mk(L,0,L,L,0,0,L,0,L,                     L,L,0,0,L,'h00a00093,L,0,L);
    tbl[9]  = mk(L,0,H,L,'h1000,'h55,L,0,L,             H,L,'h1000,'h55,L,'h00a00093,L,0,L);
    tbl[10] = mk(L,0,H,L,'h1000,'h55,H,'hcafef00d,L,    L,L,0,0,L,'h00a00093,H,'hcafef00d,L);
    tbl[11] = mk(L,0,L,L,0,0,L,0,L,                     L,L,0,0,L,'h00a00093,L,'hcafef00d,L);
    tbl[12] = mk(L,0,L,L,0,0,H,'h1111,L,                L,L,0,0,L,'h00a00093,L,'hcafef00d,L);
    tbl[13] = mk(H,'h100,H,L,'h200,0,L,0,L,             H,L,'h100,0,L,'h00a00093,L,'hcafef00d,L);
    tbl[14] = mk(H,'h100,H,L,'h200,0,H,'ha,L,           L,L,0,0,H,'ha,L,'hcafef00d,L);
    tbl[15] = mk(H,'h100,H,L,'h200,0,H,'h99,L,          H,L,'h200,0,L,'ha,L,'hcafef00d,L);
    tbl[16] = mk(H,'h100,H,L,'h200,0,H,'hb,L,           L,L,0,0,L,'ha,H,'hb,L);
    tbl[17] = mk(H,'h100,H,L,'h200,0,L,0,L,             H,L,'h100,0,L,'ha,L,'hb,L);
    tbl[18] = mk(H,'h100,H,L,'h200,0,H,'hc,L,           L,L,0,0,H,'hc,L,'hb,L);
    tbl[19] = mk(H,'h100,H,L,'h200,0,L,0,L,             H,L,'h200,0,L,'hc,L,'hb,L);
    tbl[20] = mk(H,'h100,H,L,'h200,0,H,'hd,L,           L,L,0,0,L,'hc,H,'hd,L);
    tbl[21] = mk(L,0,L,L,0,0,L,0,L,                     L,L,0,0,L,'hc,L,'hd,L);
    tbl[22] = mk(H,'h300,L,L,0,0,L,0,L,                 H,L,'h300,0,L,'hc,L,'hd,L);
    tbl[23] = mk(H,'h300,L,L,0,0,H,'he,L,               L,L,0,0,H,'he,L,'hd,L);
    tbl[24] = mk(L,0,L,L,0,0,L,0,L,                     L,L,0,0,L,'he,L,'hd,L);
    tbl[25] = mk(H,'h400,H,L,'h500,'h77,L,0,L,          H,L,'h500,'h77,L,'he,L,'hd,L);
    tbl[26] = mk(H,'h400,H,L,'h500,'h77,H,'hf,L,        L,L,0,0,L,'he,H,'hf,L);
    tbl[27] = mk(L,0,L,L,0,0,L,0,L,                     L,L,0,0,L,'he,L,'hf,L);

    nrst = 0; ins_req = 0; ins_addr = 0; dat_req = 0; dat_we = 0; dat_addr = 0; dat_wdata = 0;
    bus_ack = 0; bus_rdata = 0; err_clr = 0;
    #12;
    chk("rst bus_req", 32'(bus_req), 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_we", 32'(bus_we), 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst ins_valid", 32'(ins_valid), 0);
    chk("rst dat_valid", 32'(dat_valid), 0);
    chk("rst ins_rdata", ins_rdata, 0);
    chk("rst dat_rdata", dat_rdata, 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
    nrst = 1;

    for (int i = 0; i < 28; i++) run(tbl[i]);

`ifdef EXBUS_TIMEOUT_EN
    // fetch abort after exactly 4 bus_req cycles, NOP returned, sticky error cleared by err_clr
    for (int i = 0; i < 4; i++) run(mk(H,'h600,L,L,0,0,L,0,L, H,L,'h600,0,L,'he,L,'hf,L));
    run(mk(H,'h600,L,L,0,0,L,0,L, L,L,0,0,H,'h13,L,'hf,H));
    run(mk(L,0,L,L,0,0,L,0,L,     L,L,0,0,L,'h13,L,'hf,H));
    run(mk(L,0,L,L,0,0,L,0,L,     L,L,0,0,L,'h13,L,'hf,H));
    run(mk(L,0,L,L,0,0,L,0,H,     L,L,0,0,L,'h13,L,'hf,L));
    // ack arriving on the abort cycle completes normally
    for (int i = 0; i < 4; i++) run(mk(H,'h604,L,L,0,0,L,0,L, H,L,'h604,0,L,'h13,L,'hf,L));
    run(mk(H,'h604,L,L,0,0,H,'h42,L, L,L,0,0,H,'h42,L,'hf,L));
    run(mk(L,0,L,L,0,0,L,0,L,        L,L,0,0,L,'h42,L,'hf,L));
    // data abort with err_clr held: set beats clear, dat_rdata forced to 0
    for (int i = 0; i < 4; i++) run(mk(L,0,H,H,'h608,'h9,L,0,L, H,H,'h608,'h9,L,'h42,L,'hf,L));
    run(mk(L,0,H,H,'h608,'h9,L,0,H, L,L,0,0,L,'h42,H,0,H));
    run(mk(L,0,L,L,0,0,L,0,L,       L,L,0,0,L,'h42,L,0,H));
    run(mk(L,0,L,L,0,0,L,0,H,       L,L,0,0,L,'h42,L,0,L));
    ird_h = 'h42; drd_h = 0;
`else
    // without the timeout the bus waits indefinitely for ack
    for (int i = 0; i < 20; i++) run(mk(L,0,H,L,'h700,0,L,0,H, H,L,'h700,0,L,'he,L,'hf,L));
    run(mk(L,0,H,L,'h700,0,H,'h77,L, L,L,0,0,L,'he,H,'h77,L));
    run(mk(L,0,L,L,0,0,L,0,L,        L,L,0,0,L,'he,L,'h77,L));
    ird_h = 'he; drd_h = 'h77;
`endif

    // asynchronous reset during a data wait
    run(mk(L,0,H,L,'h800,0,L,0,L, H,L,'h800,0,L,ird_h,L,drd_h,L));
    run(mk(L,0,H,L,'h800,0,L,0,L, H,L,'h800,0,L,ird_h,L,drd_h,L));
    #2 nrst = 0;
    #1;
    chk("async bus_req", 32'(bus_req), 0);
    chk("async bus_addr", bus_addr, 0);
    chk("async dat_valid", 32'(dat_valid), 0);
    chk("async ins_rdata", ins_rdata, 0);
    chk("async dat_rdata", dat_rdata, 0);
    bus_ack = 1; bus_rdata = 'h5;
    @(posedge clk);
    #1;
    chk("rst hold bus_req", 32'(bus_req), 0);
    chk("rst hold dat_valid", 32'(dat_valid), 0);
    bus_ack = 0;
    nrst = 1;
    run(mk(H,'ha00,H,L,'hb00,0,L,0,L, H,L,'ha00,0,L,0,L,0,L));
    run(mk(H,'ha00,H,L,'hb00,0,H,'h3,L, L,L,0,0,H,'h3,L,0,L));
    run(mk(L,0,H,L,'hb00,0,L,0,L,     H,L,'hb00,0,L,'h3,L,0,L));
    run(mk(L,0,H,L,'hb00,0,H,'h4,L,   L,L,0,0,L,'h3,H,'h4,L));
    run(mk(L,0,L,L,0,0,L,0,L,         L,L,0,0,L,'h3,L,'h4,L));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
